// File: rtl/dcache_mshr_file.sv
// Miss-status holding register file for the data cache.
// Tracks outstanding line misses, rejects a second miss to a busy line,
// and hands misses to memory strictly in allocation order via an age queue.
module dcache_mshr_file #(
   parameter int unsigned NR_ENTRIES  = 4,
   parameter int unsigned ADDR_WIDTH  = 56,
   parameter int unsigned ID_WIDTH    = 2,
   parameter int unsigned LINE_OFFSET = 4,
   localparam int unsigned IDX_W      = $clog2(NR_ENTRIES),
   localparam int unsigned CNT_W      = $clog2(NR_ENTRIES + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  alloc_valid_i,
   output logic                  alloc_ready_o,
   input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
   input  logic [ID_WIDTH-1:0]   alloc_id_i,
   input  logic                  alloc_we_i,
   input  logic [63:0]           alloc_wdata_i,
   input  logic [7:0]            alloc_be_i,
   output logic [IDX_W-1:0]      alloc_idx_o,
   output logic                  miss_valid_o,
   input  logic                  miss_ready_i,
   output logic [IDX_W-1:0]      miss_idx_o,
   output logic [ADDR_WIDTH-1:0] miss_addr_o,
   output logic [ID_WIDTH-1:0]   miss_id_o,
   output logic                  miss_we_o,
   output logic [63:0]           miss_wdata_o,
   output logic [7:0]            miss_be_o,
   input  logic                  retire_valid_i,
   input  logic [IDX_W-1:0]      retire_idx_i,
   output logic                  retire_err_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [CNT_W-1:0]      count_o
);

   typedef enum logic [1:0] {FREE, PENDING, ISSUED} state_e;

   state_e                state_q [NR_ENTRIES];
   logic [ADDR_WIDTH-1:0] addr_q  [NR_ENTRIES];
   logic [ID_WIDTH-1:0]   id_q    [NR_ENTRIES];
   logic                  we_q    [NR_ENTRIES];
   logic [63:0]           wdata_q [NR_ENTRIES];
   logic [7:0]            be_q    [NR_ENTRIES];

   // age queue of entry indices; depth equals entry count so it never overflows
   logic [IDX_W-1:0]      queue_q [NR_ENTRIES];
   logic [IDX_W-1:0]      head_q, tail_q;
   logic [CNT_W-1:0]      qcnt_q, cnt_q;
   logic                  err_q;

   logic                  conflict;
   logic [IDX_W-1:0]      free_idx;
   logic                  do_alloc, do_issue, ret_ok;

   // lowest free entry and same-line conflict against all busy entries
   always_comb begin
      conflict = 1'b0;
      free_idx = '0;
      for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] == FREE)
            free_idx = IDX_W'(i);
         else if (addr_q[i][ADDR_WIDTH-1:LINE_OFFSET] == alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET])
            conflict = 1'b1;
      end
   end

   assign full_o        = (cnt_q == CNT_W'(NR_ENTRIES));
   assign empty_o       = (cnt_q == '0);
   assign count_o       = cnt_q;
   assign alloc_ready_o = !full_o && !conflict;
   assign alloc_idx_o   = free_idx;

   // head of the age queue is presented straight from registered state
   assign miss_valid_o  = (qcnt_q != '0);
   assign miss_idx_o    = queue_q[head_q];
   assign miss_addr_o   = addr_q[miss_idx_o];
   assign miss_id_o     = id_q[miss_idx_o];
   assign miss_we_o     = we_q[miss_idx_o];
   assign miss_wdata_o  = wdata_q[miss_idx_o];
   assign miss_be_o     = be_q[miss_idx_o];
   assign retire_err_o  = err_q;

   assign do_alloc = alloc_valid_i && alloc_ready_o;
   assign do_issue = miss_valid_o && miss_ready_i;
   assign ret_ok   = retire_valid_i && (state_q[retire_idx_i] == ISSUED);

   // per-entry state and field capture; alloc/issue/retire hit disjoint states
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            state_q[i] <= FREE;
            addr_q[i]  <= '0;
            id_q[i]    <= '0;
            we_q[i]    <= 1'b0;
            wdata_q[i] <= '0;
            be_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NR_ENTRIES; i++) begin
            if (do_alloc && free_idx == IDX_W'(i)) begin
               state_q[i] <= PENDING;
               addr_q[i]  <= alloc_addr_i;
               id_q[i]    <= alloc_id_i;
               we_q[i]    <= alloc_we_i;
               wdata_q[i] <= alloc_wdata_i;
               be_q[i]    <= alloc_be_i;
            end else if (do_issue && miss_idx_o == IDX_W'(i)) begin
               state_q[i] <= ISSUED;
            end else if (ret_ok && retire_idx_i == IDX_W'(i)) begin
               state_q[i] <= FREE;
            end
         end
      end
   end

   // age queue push on alloc, pop on issue; pointers wrap naturally
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NR_ENTRIES; i++) queue_q[i] <= '0;
         head_q <= '0;
         tail_q <= '0;
         qcnt_q <= '0;
      end else begin
         if (do_alloc) begin
            queue_q[tail_q] <= free_idx;
            tail_q          <= tail_q + IDX_W'(1);
         end
         if (do_issue) head_q <= head_q + IDX_W'(1);
         qcnt_q <= qcnt_q + CNT_W'(do_alloc) - CNT_W'(do_issue);
      end
   end

   // busy count and one-cycle error pulse for retiring a non-issued entry
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(do_alloc) - CNT_W'(ret_ok);
         err_q <= retire_valid_i && !ret_ok;
      end
   end

endmodule
